// File: rtl/axis_upsizer.sv
// axis_upsizer: packs cfg_data+1 narrow AXI4-Stream words into one wide beat, lane 0 first.
// Define AXIS_UPSIZER_TLAST_EN to add s_axis_tlast/m_axis_tlast, which close a word early.
module axis_upsizer #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [15:0]                   cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
`ifdef AXIS_UPSIZER_TLAST_EN
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tlast,
`endif
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);
    localparam int S = S_AXIS_TDATA_WIDTH;
    localparam int RATIO = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
    localparam int CNTR_WIDTH = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int AL = RATIO > 1 ? RATIO - 1 : 1;
    localparam logic [CNTR_WIDTH-1:0] LMAX = CNTR_WIDTH'(RATIO - 1);

    logic [CNTR_WIDTH-1:0]         cntr_q, cntr_d, len_q, len_d, cfg_len;
    logic [AL*S-1:0]               acc_q, acc_d;
    logic [(AL+1)*S-1:0]           wide;
    logic [M_AXIS_TDATA_WIDTH-1:0] mdata_q, mdata_d, word;
    logic                          mvalid_q, mvalid_d, tlast_q, tlast_d;
    logic                          beat, done, last_in;
    logic                          unused_cfg;

    assign unused_cfg = ^cfg_data[15:CNTR_WIDTH];
`ifdef AXIS_UPSIZER_TLAST_EN
    assign last_in = s_axis_tlast;
    assign m_axis_tlast = tlast_q;
`else
    assign last_in = 1'b0;
`endif
    assign m_axis_tdata = mdata_q;
    assign m_axis_tvalid = mvalid_q;

    // len follows cfg_data only while cntr==0, so ready reflects the length the next beat will use
    always_comb begin
        cfg_len = cfg_data[CNTR_WIDTH-1:0] > LMAX ? LMAX : cfg_data[CNTR_WIDTH-1:0];
        len_d = cntr_q == '0 ? cfg_len : len_q;
        s_axis_tready = ~((cntr_q == len_d || last_in) && mvalid_q && !m_axis_tready);
        beat = s_axis_tvalid & s_axis_tready;
        done = beat & (cntr_q == len_d || last_in);
        wide = {{S{1'b0}}, acc_q};
        for (int i = 0; i < RATIO; i++)
            word[i*S +: S] = CNTR_WIDTH'(i) == cntr_q ? s_axis_tdata :
                             CNTR_WIDTH'(i) < cntr_q ? wide[i*S +: S] : '0;
        acc_d = acc_q;
        if (done)
            acc_d = '0;
        else if (beat)
            acc_d[cntr_q*S +: S] = s_axis_tdata;
        cntr_d = done ? '0 : beat ? cntr_q + 1'b1 : cntr_q;
        mvalid_d = done | (mvalid_q & ~m_axis_tready);
        mdata_d = done ? word : mdata_q;
        tlast_d = done ? last_in : tlast_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cntr_q <= '0;
            len_q <= '0;
            acc_q <= '0;
            mdata_q <= '0;
            mvalid_q <= 1'b0;
            tlast_q <= 1'b0;
        end else begin
            cntr_q <= cntr_d;
            len_q <= len_d;
            acc_q <= acc_d;
            mdata_q <= mdata_d;
            mvalid_q <= mvalid_d;
            tlast_q <= tlast_d;
        end
    end
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: directed table-driven bench for axis_upsizer (32 -> 128 bits).
module tb_axis_upsizer;
    logic         aclk = 1'b0;
    logic         aresetn;
    logic [15:0]  cfg_data;
    logic [31:0]  s_tdata;
    logic         s_tvalid, s_tready, s_tlast;
    logic [127:0] m_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0]  cfg;
        logic [31:0]  d;
        logic         v, mr, tl, er, ev, etl;
        logic [127:0] ed;
    } vec_t;

    vec_t tv[$];

    always #5 aclk = ~aclk;

    axis_upsizer dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cfg_data(cfg_data),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
`ifdef AXIS_UPSIZER_TLAST_EN
        .s_axis_tlast(s_tlast),
        .m_axis_tlast(m_tlast),
`endif
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

`ifndef AXIS_UPSIZER_TLAST_EN
    assign m_tlast = 1'b0;
`endif

    function automatic vec_t mk(logic [15:0] cfg, logic [31:0] d, logic v, logic mr,
                                logic er, logic ev, logic [127:0] ed,
                                logic tl = 1'b0, logic etl = 1'b0);
        vec_t t;
        t.cfg = cfg; t.d = d; t.v = v; t.mr = mr; t.er = er;
        t.ev = ev; t.ed = ed; t.tl = tl; t.etl = etl;
        return t;
    endfunction

    task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int idx);
        @(negedge aclk);
        cfg_data = t.cfg; s_tdata = t.d; s_tvalid = t.v; m_tready = t.mr; s_tlast = t.tl;
        #1;
        check($sformatf("s_tready[%0d]", idx), {127'b0, s_tready}, {127'b0, t.er});
        @(posedge aclk);
        #1;
        check($sformatf("m_tvalid[%0d]", idx), {127'b0, m_tvalid}, {127'b0, t.ev});
        if (t.ev) begin
            check($sformatf("m_tdata[%0d]", idx), m_tdata, t.ed);
`ifdef AXIS_UPSIZER_TLAST_EN
            check($sformatf("m_tlast[%0d]", idx), {127'b0, m_tlast}, {127'b0, t.etl});
`endif
        end
    endtask

    initial begin
        aresetn = 1'b0; cfg_data = 16'd3; s_tdata = '0; s_tvalid = 1'b0;
        m_tready = 1'b1; s_tlast = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_m_tvalid", {127'b0, m_tvalid}, 128'd0);
        check("rst_m_tdata", m_tdata, 128'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rst_s_tready", {127'b0, s_tready}, 128'd1);

        // basic 4-word pack
        tv.push_back(mk(3, 32'h11, 1, 1, 1, 0, 0));
        tv.push_back(mk(3, 32'h22, 1, 1, 1, 0, 0));
        tv.push_back(mk(3, 32'h33, 1, 1, 1, 0, 0));
        tv.push_back(mk(3, 32'h44, 1, 1, 1, 1, 128'h00000044_00000033_00000022_00000011));
        // pairs, upper lanes zero, no bubbles
        for (int i = 1; i <= 8; i++)
            tv.push_back(mk(1, 32'(i), 1, 1, 1, (i % 2) == 0,
                            {64'd0, 32'(i), 32'(i - 1)}));
        tv.push_back(mk(3, 0, 0, 1, 1, 0, 0));
        // output stalled: 4 fill, 3 more accepted, 8th held off until handshake
        for (int i = 1; i <= 8; i++)
            tv.push_back(mk(3, 32'hA0 + 32'(i), 1, 0, i < 8, i >= 4,
                            128'h000000A4_000000A3_000000A2_000000A1));
        tv.push_back(mk(3, 32'hA8, 1, 1, 1, 1, 128'h000000A8_000000A7_000000A6_000000A5));
        tv.push_back(mk(3, 0, 0, 1, 1, 0, 0));
        // cfg change mid-word
        tv.push_back(mk(3, 32'hC1, 1, 1, 1, 0, 0));
        tv.push_back(mk(3, 32'hC2, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 32'hC3, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 32'hC4, 1, 1, 1, 1, 128'h000000C4_000000C3_000000C2_000000C1));
        tv.push_back(mk(0, 32'hC5, 1, 1, 1, 1, 128'h000000C5));
        tv.push_back(mk(0, 32'hC6, 1, 1, 1, 1, 128'h000000C6));
        // only the low counter bits of cfg_data matter (5 -> 1), and cfg 2 zeroes lane 3
        tv.push_back(mk(16'h0005, 32'hD1, 1, 1, 1, 0, 0));
        tv.push_back(mk(16'h0005, 32'hD2, 1, 1, 1, 1, 128'h000000D2_000000D1));
        tv.push_back(mk(2, 32'hE1, 1, 1, 1, 0, 0));
        tv.push_back(mk(2, 32'hE2, 1, 1, 1, 0, 0));
        tv.push_back(mk(2, 32'hE3, 1, 1, 1, 1, 128'h000000E3_000000E2_000000E1));
        tv.push_back(mk(3, 0, 0, 1, 1, 0, 0));
        foreach (tv[i]) run(tv[i], i);

        // reset mid-word drops the partial word
        run(mk(3, 32'hF1, 1, 1, 1, 0, 0), 100);
        run(mk(3, 32'hF2, 1, 1, 1, 0, 0), 101);
        @(negedge aclk);
        aresetn = 1'b0; s_tdata = 32'hF3; s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        check("midrst_m_tvalid", {127'b0, m_tvalid}, 128'd0);
        check("midrst_m_tdata", m_tdata, 128'd0);
        @(negedge aclk);
        aresetn = 1'b1; s_tvalid = 1'b0;
        #1;
        check("midrst_s_tready", {127'b0, s_tready}, 128'd1);
        run(mk(3, 32'h91, 1, 1, 1, 0, 0), 102);
        run(mk(3, 32'h92, 1, 1, 1, 0, 0), 103);
        run(mk(3, 32'h93, 1, 1, 1, 0, 0), 104);
        run(mk(3, 32'h94, 1, 1, 1, 1, 128'h00000094_00000093_00000092_00000091), 105);

`ifdef AXIS_UPSIZER_TLAST_EN
        run(mk(3, 32'hA, 1, 1, 1, 0, 0), 200);
        run(mk(3, 32'hB, 1, 1, 1, 1, 128'h0000000B_0000000A, 1, 1), 201);
        run(mk(3, 32'h1, 1, 1, 1, 0, 0), 202);
        run(mk(3, 32'h2, 1, 1, 1, 0, 0), 203);
        run(mk(3, 32'h3, 1, 1, 1, 0, 0), 204);
        run(mk(3, 32'h4, 1, 1, 1, 1, 128'h00000004_00000003_00000002_00000001, 0, 0), 205);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
